// File: rtl/clk_divider.sv
// Integer clock divider: registered square wave, rising-edge tick and phase count.
// Low phase is X - X/2 cycles, so odd ratios put the extra cycle in the low half.
module clk_divider #(
  parameter  int X = 16,
  localparam int W = (X < 2) ? 1 : $clog2(X)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         clk_reduced,
  output logic         tick,
  output logic [W-1:0] cnt
);

  localparam int L = X - X / 2;

  if (X < 2) begin : g_bad_ratio
    $error("clk_divider: X must be >= 2");
  end

  // Power-up value lets an unreset instance still produce a clean waveform.
  logic [W-1:0] cnt_q  = '0;
  logic         clk_q  = 1'b0;
  logic         tick_q = 1'b0;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt_q == W'(X - 1)) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_next;
      clk_q  <= (cnt_next >= W'(L));
      tick_q <= (cnt_next == W'(L));
    end
  end

  assign cnt         = cnt_q;
  assign clk_reduced = clk_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: ratios 16, 5, 2 and an instance that never sees reset.
// Expected outputs come from the edge count since the last reset, modulo X.
module tb_clk_divider;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_idle;

  logic       cr16, tk16;
  logic [3:0] c16;
  logic       cr5, tk5;
  logic [2:0] c5;
  logic       cr2, tk2;
  logic [0:0] c2;
  logic       crn, tkn;
  logic [3:0] cn;

  int checks = 0;
  int errors = 0;

  // edges since the last edge that sampled rst high
  int k_rst = 0;
  // edges since time zero for the never-reset instance
  int k_all = 0;

  always #1 clk = ~clk;

  always @(posedge clk) begin
    k_rst <= rst ? 0 : k_rst + 1;
    k_all <= k_all + 1;
  end

  clk_divider #(.X(16)) u16 (
    .clk(clk), .rst(rst), .clk_reduced(cr16), .tick(tk16), .cnt(c16));
  clk_divider #(.X(5)) u5 (
    .clk(clk), .rst(rst), .clk_reduced(cr5), .tick(tk5), .cnt(c5));
  clk_divider #(.X(2)) u2 (
    .clk(clk), .rst(rst), .clk_reduced(cr2), .tick(tk2), .cnt(c2));
  clk_divider #(.X(16)) un (
    .clk(clk), .rst(rst_idle), .clk_reduced(crn), .tick(tkn), .cnt(cn));

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({c16, cr16, tk16} !== 6'd0) begin
        errors++;
        $display("FAIL reset16 got cnt=%0d clk=%b tick=%b want 0 0 0", c16, cr16, tk16);
      end
      checks++;
      if ({c5, cr5, tk5} !== 5'd0) begin
        errors++;
        $display("FAIL reset5 got cnt=%0d clk=%b tick=%b want 0 0 0", c5, cr5, tk5);
      end
      checks++;
      if ({c2, cr2, tk2} !== 3'd0) begin
        errors++;
        $display("FAIL reset2 got cnt=%0d clk=%b tick=%b want 0 0 0", c2, cr2, tk2);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_x16_wave;
    int ticks = 0;
    int rises = 0;
    int ph;
    logic prev = 1'b0;
    pulse_reset(3);
    repeat (1024) begin
      @(negedge clk);
      ph = k_rst % 16;
      checks++;
      if (c16 !== 4'(ph) || cr16 !== (ph >= 8) || tk16 !== (ph == 8)) begin
        errors++;
        $display("FAIL x16_wave got cnt=%0d clk=%b tick=%b want %0d %b %b",
                 c16, cr16, tk16, ph, ph >= 8, ph == 8);
      end
      if (tk16) ticks++;
      if (cr16 && !prev) begin
        rises++;
        checks++;
        if (tk16 !== 1'b1) begin
          errors++;
          $display("FAIL x16_tick_align got tick=%b want 1 at rising edge", tk16);
        end
      end
      prev = cr16;
    end
    checks++;
    if (ticks != 64) begin
      errors++;
      $display("FAIL x16_tick_count got %0d want 64", ticks);
    end
    checks++;
    if (rises != 64) begin
      errors++;
      $display("FAIL x16_rise_count got %0d want 64", rises);
    end
  endtask

  task automatic test_x5;
    int ph;
    int low = 0;
    int high = 0;
    pulse_reset(2);
    repeat (50) begin
      @(negedge clk);
      ph = k_rst % 5;
      if (cr5) high++; else low++;
      checks++;
      if (c5 !== 3'(ph) || cr5 !== (ph >= 3) || tk5 !== (ph == 3)) begin
        errors++;
        $display("FAIL x5_wave got cnt=%0d clk=%b tick=%b want %0d %b %b",
                 c5, cr5, tk5, ph, ph >= 3, ph == 3);
      end
    end
    checks++;
    if (low != 30 || high != 20) begin
      errors++;
      $display("FAIL x5_duty got low=%0d high=%0d want 30 20", low, high);
    end
  endtask

  task automatic test_x2;
    logic want = 1'b1;
    pulse_reset(2);
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (cr2 !== want || tk2 !== want || c2 !== want) begin
        errors++;
        $display("FAIL x2_toggle got clk=%b tick=%b cnt=%0d want %b",
                 cr2, tk2, c2, want);
      end
      want = ~want;
    end
  endtask

  task automatic test_mid_reset;
    int budget = 40;
    pulse_reset(1);
    @(negedge clk);
    while (c16 !== 4'd11 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL mid_reset_wait got cnt=%0d want 11 within 40 cycles", c16);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({c16, cr16, tk16} !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d clk=%b tick=%b want 0 0 0", c16, cr16, tk16);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (c16 !== 4'(i % 16) || cr16 !== ((i % 16) >= 8)) begin
        errors++;
        $display("FAIL mid_reset_seq got cnt=%0d clk=%b want %0d %b",
                 c16, cr16, i % 16, (i % 16) >= 8);
      end
    end
  endtask

  task automatic test_no_reset;
    int ph;
    repeat (64) begin
      @(negedge clk);
      ph = k_all % 16;
      checks++;
      if (cn !== 4'(ph) || crn !== (ph >= 8) || tkn !== (ph == 8)) begin
        errors++;
        $display("FAIL no_reset got cnt=%0d clk=%b tick=%b want %0d %b %b",
                 cn, crn, tkn, ph, ph >= 8, ph == 8);
      end
    end
  endtask

  task automatic test_random_reset;
    int p16, p5, p2;
    repeat (2000) begin
      rst = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      p16 = k_rst % 16;
      p5  = k_rst % 5;
      p2  = k_rst % 2;
      checks++;
      if (c16 !== 4'(p16) || cr16 !== (p16 >= 8) || tk16 !== (p16 == 8)) begin
        errors++;
        $display("FAIL rand16 got cnt=%0d clk=%b tick=%b want %0d", c16, cr16, tk16, p16);
      end
      checks++;
      if (c5 !== 3'(p5) || cr5 !== (p5 >= 3) || tk5 !== (p5 == 3)) begin
        errors++;
        $display("FAIL rand5 got cnt=%0d clk=%b tick=%b want %0d", c5, cr5, tk5, p5);
      end
      checks++;
      if (c2 !== 1'(p2) || cr2 !== (p2 == 1) || tk2 !== (p2 == 1)) begin
        errors++;
        $display("FAIL rand2 got cnt=%0d clk=%b tick=%b want %0d", c2, cr2, tk2, p2);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst_idle = 1'b0;
    test_no_reset;
    test_reset;
    test_x16_wave;
    test_x5;
    test_x2;
    test_mid_reset;
    test_random_reset;
    test_no_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
